// File: rtl/pcgen_a2.sv
// Fetch PC generator with a slot-aware set-associative BTB and 2-bit counters.
// Define PCGEN_A2_RAS_EN to build the speculative/committed return address stack.
module pcgen_a2 #(
  parameter logic [31:0] START_ADDR  = 32'h0,
  parameter int unsigned FETCH_WIDTH = 4,
  parameter int unsigned BTB_SETS    = 64,
  parameter int unsigned BTB_WAYS    = 2,
  parameter int unsigned RAS_ENTRIES = 16,
  localparam int unsigned OFF  = $clog2(FETCH_WIDTH),
  localparam int unsigned WAYW = (BTB_WAYS > 1) ? $clog2(BTB_WAYS) : 1
) (
  input  logic                   core_clock_i,
  input  logic                   core_reset_ni,
  input  logic                   core_flush_i,
  input  logic [29:0]            core_flush_pc,
  input  logic                   enable_branch_pred,
  input  logic                   fetch_busy_i,
  input  logic                   upd_valid_i,
  input  logic                   upd_alloc_i,
  input  logic [29:0]            upd_pc_i,
  input  logic [29:0]            upd_target_i,
  input  logic [1:0]             upd_type_i,
  input  logic                   upd_taken_i,
  input  logic [1:0]             upd_cntr_i,
  input  logic [WAYW-1:0]        upd_way_i,
  input  logic                   inval_i,
  input  logic [29:0]            inval_pc_i,
  input  logic                   call_commit_i,
  input  logic                   ret_commit_i,
  output logic                   fetch_valid_o,
  output logic [29:0]            fetch_pc_o,
  output logic [FETCH_WIDTH-1:0] fetch_mask_o,
  output logic                   fetch_pred_hit_o,
  output logic [OFF-1:0]         fetch_pred_slot_o,
  output logic [WAYW-1:0]        fetch_pred_way_o,
  output logic [1:0]             fetch_pred_type_o,
  output logic [1:0]             fetch_pred_cntr_o,
  output logic [29:0]            fetch_pred_target_o
);

  localparam int unsigned IDX  = $clog2(BTB_SETS);
  localparam int unsigned TAGW = 30 - OFF - IDX;
  localparam int unsigned BLKW = 30 - OFF;

  function automatic logic [1:0] sat2(input logic [1:0] c, input logic up);
    if (up) return (c == 2'b11) ? c : c + 2'b01;
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  logic alloc_go, stall_upd, cupd_go, fetch_go;
  assign alloc_go  = upd_valid_i & upd_alloc_i;
  assign stall_upd = alloc_go | inval_i;
  assign cupd_go   = upd_valid_i & ~upd_alloc_i & ~inval_i;
  assign fetch_go  = ~core_flush_i & ~stall_upd & ~fetch_busy_i;

  logic [BTB_WAYS-1:0] bt_vld_q  [BTB_SETS];
  logic [WAYW-1:0]     bt_rr_q   [BTB_SETS];
  logic [TAGW-1:0]     bt_tag_q  [BTB_SETS][BTB_WAYS];
  logic [OFF-1:0]      bt_slot_q [BTB_SETS][BTB_WAYS];
  logic [1:0]          bt_type_q [BTB_SETS][BTB_WAYS];
  logic [1:0]          bt_cntr_q [BTB_SETS][BTB_WAYS];
  logic [29:0]         bt_tgt_q  [BTB_SETS][BTB_WAYS];

  logic [29:0]     pc_q, lk_pc;
  logic [IDX-1:0]  lk_idx, upd_idx;
  logic [TAGW-1:0] lk_tag;
  logic [OFF-1:0]  lk_off;

  // One lookup port is shared between fetch, allocation and invalidation.
  assign lk_pc   = alloc_go ? upd_pc_i : inval_i ? inval_pc_i : pc_q;
  assign lk_idx  = lk_pc[OFF+IDX-1:OFF];
  assign lk_tag  = lk_pc[29:OFF+IDX];
  assign lk_off  = lk_pc[OFF-1:0];
  assign upd_idx = upd_pc_i[OFF+IDX-1:OFF];

  logic [BTB_WAYS-1:0] exact;
  logic                fw_found, al_free;
  logic [WAYW-1:0]     fw_way, al_way, free_way;
  logic [OFF-1:0]      fw_slot;

  always_comb begin
    exact    = '0;
    fw_found = 1'b0;
    fw_way   = '0;
    fw_slot  = '0;
    al_free  = 1'b0;
    free_way = '0;
    for (int w = 0; w < BTB_WAYS; w++) begin
      if (bt_vld_q[lk_idx][w] && bt_tag_q[lk_idx][w] == lk_tag) begin
        if (bt_slot_q[lk_idx][w] == lk_off) exact[w] = 1'b1;
        if (bt_slot_q[lk_idx][w] >= lk_off &&
            (!fw_found || bt_slot_q[lk_idx][w] < fw_slot)) begin
          fw_found = 1'b1;
          fw_way   = WAYW'(w);
          fw_slot  = bt_slot_q[lk_idx][w];
        end
      end
      if (!bt_vld_q[lk_idx][w] && !al_free) begin
        al_free  = 1'b1;
        free_way = WAYW'(w);
      end
    end
    al_way = bt_rr_q[lk_idx];
    if (al_free) al_way = free_way;
    for (int w = BTB_WAYS - 1; w >= 0; w--) begin
      if (exact[w]) al_way = WAYW'(w);
    end
  end

  logic [1:0]  fw_type, fw_cntr;
  logic [29:0] fw_tgt, seq_pc, next_pc, push_val, ras_top;
  logic        redirect, pred_hit, ras_nonempty;
  logic [FETCH_WIDTH-1:0] mask_d;

  assign fw_type  = bt_type_q[lk_idx][fw_way];
  assign fw_cntr  = bt_cntr_q[lk_idx][fw_way];
  assign fw_tgt   = (fw_type == 2'b11 && ras_nonempty) ? ras_top : bt_tgt_q[lk_idx][fw_way];
  assign pred_hit = enable_branch_pred & fw_found;
  assign redirect = pred_hit & ((fw_type != 2'b00) | fw_cntr[1]);
  assign seq_pc   = {pc_q[29:OFF] + BLKW'(1), {OFF{1'b0}}};
  assign next_pc  = redirect ? fw_tgt : seq_pc;
  assign push_val = {pc_q[29:OFF], fw_slot} + 30'd1;

  always_comb begin
    mask_d = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      mask_d[i] = (OFF'(i) >= pc_q[OFF-1:0]) && (!redirect || OFF'(i) <= fw_slot);
    end
  end

  logic                   fv_q, phit_q;
  logic [29:0]            fpc_q, ptgt_q;
  logic [FETCH_WIDTH-1:0] fmask_q;
  logic [OFF-1:0]         pslot_q;
  logic [WAYW-1:0]        pway_q;
  logic [1:0]             ptype_q, pcntr_q;

  always_ff @(posedge core_clock_i or negedge core_reset_ni) begin
    if (!core_reset_ni) begin
      pc_q    <= START_ADDR[31:2];
      fv_q    <= 1'b0;
      fpc_q   <= '0;
      fmask_q <= '0;
      phit_q  <= 1'b0;
      pslot_q <= '0;
      pway_q  <= '0;
      ptype_q <= '0;
      pcntr_q <= '0;
      ptgt_q  <= '0;
    end else if (core_flush_i) begin
      pc_q   <= core_flush_pc;
      fv_q   <= 1'b0;
      phit_q <= 1'b0;
    end else if (stall_upd) begin
      fv_q   <= 1'b0;
      phit_q <= 1'b0;
    end else if (fetch_go) begin
      pc_q    <= next_pc;
      fv_q    <= 1'b1;
      fpc_q   <= {pc_q[29:OFF], {OFF{1'b0}}};
      fmask_q <= mask_d;
      phit_q  <= pred_hit;
      pslot_q <= pred_hit ? fw_slot : '0;
      pway_q  <= pred_hit ? fw_way : '0;
      ptype_q <= pred_hit ? fw_type : '0;
      pcntr_q <= pred_hit ? fw_cntr : '0;
      ptgt_q  <= pred_hit ? fw_tgt : '0;
    end
  end

  // Round-robin pointer only advances when a valid, non-matching way is evicted.
  always_ff @(posedge core_clock_i or negedge core_reset_ni) begin
    if (!core_reset_ni) begin
      for (int s = 0; s < BTB_SETS; s++) begin
        bt_vld_q[s] <= '0;
        bt_rr_q[s]  <= '0;
      end
    end else if (alloc_go) begin
      bt_vld_q[lk_idx][al_way] <= 1'b1;
      if (!(|exact) && !al_free)
        bt_rr_q[lk_idx] <= (BTB_WAYS == 1) ? '0 : bt_rr_q[lk_idx] + WAYW'(1);
    end else if (inval_i) begin
      bt_vld_q[lk_idx] <= bt_vld_q[lk_idx] & ~exact;
    end
  end

  always_ff @(posedge core_clock_i) begin
    if (alloc_go) begin
      bt_tag_q[lk_idx][al_way]  <= lk_tag;
      bt_slot_q[lk_idx][al_way] <= lk_off;
      bt_type_q[lk_idx][al_way] <= upd_type_i;
      bt_cntr_q[lk_idx][al_way] <= sat2(upd_cntr_i, upd_taken_i);
      bt_tgt_q[lk_idx][al_way]  <= upd_target_i;
    end else if (cupd_go) begin
      bt_cntr_q[upd_idx][upd_way_i] <= sat2(bt_cntr_q[upd_idx][upd_way_i], upd_taken_i);
    end
  end

`ifdef PCGEN_A2_RAS_EN
  localparam int unsigned RPW = (RAS_ENTRIES > 1) ? $clog2(RAS_ENTRIES) : 1;
  localparam int unsigned RPC = RPW + 1;
  localparam logic [RPW:0] RFULL = RPC'(RAS_ENTRIES);

  function automatic logic [RPW:0] cnt_inc(input logic [RPW:0] c);
    return (c == RFULL) ? c : c + RPC'(1);
  endfunction

  logic [29:0]    ras_q [RAS_ENTRIES];
  logic [RPW-1:0] sp_q, cp_q;
  logic [RPW:0]   scnt_q, ccnt_q;
  logic           push_go, pop_go, acall, aret;

  assign push_go      = fetch_go & redirect & (fw_type == 2'b01);
  assign pop_go       = fetch_go & redirect & (fw_type == 2'b11);
  assign acall        = alloc_go & (upd_type_i == 2'b01);
  assign aret         = alloc_go & (upd_type_i == 2'b11);
  assign ras_nonempty = (scnt_q != '0);
  assign ras_top      = ras_q[sp_q];

  always_ff @(posedge core_clock_i or negedge core_reset_ni) begin
    if (!core_reset_ni) begin
      sp_q   <= '0;
      scnt_q <= '0;
      cp_q   <= '0;
      ccnt_q <= '0;
    end else begin
      if (core_flush_i) begin
        sp_q   <= cp_q;
        scnt_q <= ccnt_q;
      end else if (acall) begin
        sp_q   <= cp_q + RPW'(1);
        scnt_q <= cnt_inc(ccnt_q);
      end else if (aret) begin
        sp_q   <= (ccnt_q != '0) ? cp_q - RPW'(1) : cp_q;
        scnt_q <= (ccnt_q != '0) ? ccnt_q - RPC'(1) : '0;
      end else if (push_go) begin
        sp_q   <= sp_q + RPW'(1);
        scnt_q <= cnt_inc(scnt_q);
      end else if (pop_go && scnt_q != '0) begin
        sp_q   <= sp_q - RPW'(1);
        scnt_q <= scnt_q - RPC'(1);
      end
      if (call_commit_i) begin
        cp_q   <= cp_q + RPW'(1);
        ccnt_q <= cnt_inc(ccnt_q);
      end else if (ret_commit_i && ccnt_q != '0) begin
        cp_q   <= cp_q - RPW'(1);
        ccnt_q <= ccnt_q - RPC'(1);
      end
    end
  end

  always_ff @(posedge core_clock_i) begin
    if (acall)        ras_q[cp_q + RPW'(1)] <= upd_pc_i + 30'd1;
    else if (push_go) ras_q[sp_q + RPW'(1)] <= push_val;
  end
`else
  logic unused_ras;
  assign ras_nonempty = 1'b0;
  assign ras_top      = '0;
  assign unused_ras   = ^{call_commit_i, ret_commit_i, push_val, RAS_ENTRIES[0]};
`endif

  assign fetch_valid_o       = fv_q;
  assign fetch_pc_o          = fpc_q;
  assign fetch_mask_o        = fmask_q;
  assign fetch_pred_hit_o    = phit_q;
  assign fetch_pred_slot_o   = pslot_q;
  assign fetch_pred_way_o    = pway_q;
  assign fetch_pred_type_o   = ptype_q;
  assign fetch_pred_cntr_o   = pcntr_q;
  assign fetch_pred_target_o = ptgt_q;

endmodule
